// File: rtl/conv_pkg.sv
// conv_pkg: shared types and sizing helpers for the conv operand loader.
//   loader_state_t - loader FSM states
//   calc_*         - derived sizes (padding, tile width, kernel words, buffer depth, address width)
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_K,
        LOAD_A,
        READY
    } loader_state_t;

    // Border padding on each side of the kernel window.
    function automatic int calc_p(input int k);
        return k / 2;
    endfunction

    // Columns owned by one tile.
    function automatic int calc_tw(input int w, input int nb_tiles);
        return w / nb_tiles;
    endfunction

    // Kernel words per image.
    function automatic int calc_kw(input int co, input int ci, input int k);
        return co * ci * k * k;
    endfunction

    // Activation buffer holds the widest band: the tile plus a halo on both sides.
    function automatic int calc_a_depth(input int tw, input int p, input int h, input int ci);
        return (tw + 2 * p) * h * ci;
    endfunction

    function automatic int calc_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/loader_ram.sv
// loader_ram: simple dual-port buffer, one write port and one registered read port.
//   clk_i, rst_ni      - clock, async active-low reset (read register only)
//   we_i/waddr_i/wdata_i - write port
//   re_i/raddr_i       - read request; rdata_o updates the next cycle and holds otherwise
//   rdata_o            - registered read data
// Storage is not reset.
module loader_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/operand_loader.sv
// operand_loader: buffers the kernel (b) and one column band of activations (a) per tile,
// then serves indexed reads with 1-cycle latency and zero padding at the map borders.
//   clk, arst_n_in           - clock, async active-low reset
//   load_req                 - pulse: load the next tile (honoured in IDLE/READY only)
//   a_input/a_valid/a_ready  - activation stream (column, then row, then inch innermost)
//   b_input/b_valid/b_ready  - kernel stream (outch, inch, ky, kx innermost)
//   data_ready, tile_idx     - tile buffered / tile currently held
//   int_mem_re, ky..x        - read strobe and indices
//   a_out, b_out, rd_valid   - read data, valid the cycle after an accepted read
module operand_loader
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH         = 16,
    parameter int FEATURE_MAP_WIDTH  = 128,
    parameter int FEATURE_MAP_HEIGHT = 128,
    parameter int INPUT_NB_CHANNELS  = 2,
    parameter int OUTPUT_NB_CHANNELS = 16,
    parameter int KERNEL_SIZE        = 3,
    parameter int NB_TILES           = 2
) (
    input  logic                  clk,
    input  logic                  arst_n_in,
    input  logic                  load_req,
    input  logic [DATA_WIDTH-1:0] a_input,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [DATA_WIDTH-1:0] b_input,
    input  logic                  b_valid,
    output logic                  b_ready,
    output logic                  data_ready,
    output logic [31:0]           tile_idx,
    input  logic                  int_mem_re,
    input  logic [31:0]           ky,
    input  logic [31:0]           kx,
    input  logic [31:0]           outch,
    input  logic [31:0]           inch,
    input  logic [31:0]           y,
    input  logic [31:0]           x,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic                  rd_valid
);

    localparam int W       = FEATURE_MAP_WIDTH;
    localparam int H       = FEATURE_MAP_HEIGHT;
    localparam int CI      = INPUT_NB_CHANNELS;
    localparam int K       = KERNEL_SIZE;
    localparam int P       = calc_p(K);
    localparam int TW      = calc_tw(W, NB_TILES);
    localparam int KW      = calc_kw(OUTPUT_NB_CHANNELS, CI, K);
    localparam int A_DEPTH = calc_a_depth(TW, P, H, CI);
    localparam int K_AW    = calc_aw(KW);
    localparam int A_AW    = calc_aw(A_DEPTH);

    localparam logic signed [32:0] P_S  = 33'(P);
    localparam logic signed [32:0] W_S  = 33'(W);
    localparam logic signed [32:0] H_S  = 33'(H);
    localparam logic signed [32:0] CI_S = 33'(CI);

    loader_state_t   state_q, state_d;
    logic [31:0]     tile_q, tile_d;
    logic [K_AW-1:0] b_cnt_q, b_cnt_d;
    logic [A_AW-1:0] a_cnt_q, a_cnt_d;
    logic            rd_valid_q;
    logic            pad_q;

    // Column band of the current tile, including the halo columns.
    int x0, band_start, band_end, a_words;

    always_comb begin
        x0         = int'(tile_q) * TW;
        band_start = (x0 > P) ? x0 - P : 0;
        band_end   = (x0 + TW - 1 + P > W - 1) ? W - 1 : x0 + TW - 1 + P;
        a_words    = (band_end - band_start + 1) * H * CI;
    end

    logic b_hs, a_hs, b_last, a_last;

    assign b_hs   = b_valid && b_ready;
    assign a_hs   = a_valid && a_ready;
    assign b_last = (b_cnt_q == K_AW'(KW - 1));
    assign a_last = (a_cnt_q == A_AW'(a_words - 1));

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d    = state_q;
        tile_d     = tile_q;
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        data_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_req) begin
                    state_d = (tile_q == '0) ? LOAD_K : LOAD_A;
                end
            end
            LOAD_K: begin
                b_ready = 1'b1;
                if (b_hs && b_last) begin
                    state_d = LOAD_A;
                end
            end
            LOAD_A: begin
                a_ready = 1'b1;
                if (a_hs && a_last) begin
                    state_d = READY;
                end
            end
            READY: begin
                data_ready = 1'b1;
                if (load_req) begin
                    // Wrapping to tile 0 starts a new image, so the kernel is reloaded.
                    tile_d  = (tile_q == 32'(NB_TILES - 1)) ? '0 : tile_q + 32'd1;
                    state_d = (tile_d == '0) ? LOAD_K : LOAD_A;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stream order matches buffer address order, so a flat count is the write address.
    always_comb begin
        b_cnt_d = b_cnt_q;
        a_cnt_d = a_cnt_q;
        if (b_hs) begin
            b_cnt_d = b_last ? '0 : b_cnt_q + K_AW'(1);
        end
        if (a_hs) begin
            a_cnt_d = a_last ? '0 : a_cnt_q + A_AW'(1);
        end
    end

    // ---------------------------------------------------------------- read path
    logic                rd_accept;
    logic signed [32:0]  row_s, col_s, a_addr_s;
    logic                row_in_map, col_in_map, col_in_band, in_map;
    logic [31:0]         b_addr_full;
    logic [A_AW-1:0]     a_raddr;
    logic [K_AW-1:0]     b_raddr;
    logic [DATA_WIDTH-1:0] a_rdata, b_rdata;

    assign rd_accept = int_mem_re && (state_q == READY);

    always_comb begin
        row_s       = $signed({1'b0, y}) + $signed({1'b0, ky}) - P_S;
        col_s       = $signed({1'b0, x}) + $signed({1'b0, kx}) - P_S;
        row_in_map  = (row_s >= 33'sd0) && (row_s < H_S);
        col_in_map  = (col_s >= 33'sd0) && (col_s < W_S);
        col_in_band = (col_s >= 33'(band_start)) && (col_s <= 33'(band_end));
        in_map      = row_in_map && col_in_map;
        a_addr_s    = ((col_s - 33'(band_start)) * H_S + row_s) * CI_S + $signed({1'b0, inch});
        b_addr_full = ((outch * 32'(CI) + inch) * 32'(K) + ky) * 32'(K) + kx;
        a_raddr     = a_addr_s[A_AW-1:0];
        b_raddr     = b_addr_full[K_AW-1:0];
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^{a_addr_s[32:A_AW], b_addr_full[31:K_AW]};

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q    <= IDLE;
            tile_q     <= '0;
            b_cnt_q    <= '0;
            a_cnt_q    <= '0;
            rd_valid_q <= 1'b0;
            pad_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tile_q     <= tile_d;
            b_cnt_q    <= b_cnt_d;
            a_cnt_q    <= a_cnt_d;
            rd_valid_q <= rd_accept;
            // Padding flag only moves with an accepted read so a_out holds otherwise.
            if (rd_accept) begin
                pad_q <= !in_map;
            end
        end
    end

    loader_ram #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (KW)
    ) u_kernel_ram (
        .clk_i   (clk),
        .rst_ni  (arst_n_in),
        .we_i    (b_hs),
        .waddr_i (b_cnt_q),
        .wdata_i (b_input),
        .re_i    (rd_accept),
        .raddr_i (b_raddr),
        .rdata_o (b_rdata)
    );

    // Padded reads skip the RAM entirely.
    loader_ram #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (A_DEPTH)
    ) u_act_ram (
        .clk_i   (clk),
        .rst_ni  (arst_n_in),
        .we_i    (a_hs),
        .waddr_i (a_cnt_q),
        .wdata_i (a_input),
        .re_i    (rd_accept && in_map),
        .raddr_i (a_raddr),
        .rdata_o (a_rdata)
    );

    assign a_out    = pad_q ? '0 : a_rdata;
    assign b_out    = b_rdata;
    assign rd_valid = rd_valid_q;
    assign tile_idx = tile_q;

    // A column inside the map but outside the buffered band was never loaded.
    col_in_band_a : assert property (@(posedge clk) disable iff (!arst_n_in)
        (rd_accept && col_in_map) |-> col_in_band);

endmodule

// File: tb/tb_operand_loader.sv
module tb_operand_loader;

    localparam int DW = 16;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int CI = 2;
    localparam int CO = 2;
    localparam int K  = 3;
    localparam int NT = 2;
    localparam int TW = W / NT;
    localparam int P  = K / 2;

    logic          clk = 1'b0;
    logic          arst_n_in;
    logic          load_req;
    logic [DW-1:0] a_input, b_input;
    logic          a_valid, b_valid, a_ready, b_ready;
    logic          data_ready;
    logic [31:0]   tile_idx;
    logic          int_mem_re;
    logic [31:0]   ky, kx, outch, inch, y, x;
    logic [DW-1:0] a_out, b_out;
    logic          rd_valid;

    always #5 clk = ~clk;

    operand_loader #(
        .DATA_WIDTH         (DW),
        .FEATURE_MAP_WIDTH  (W),
        .FEATURE_MAP_HEIGHT (H),
        .INPUT_NB_CHANNELS  (CI),
        .OUTPUT_NB_CHANNELS (CO),
        .KERNEL_SIZE        (K),
        .NB_TILES           (NT)
    ) dut (
        .clk        (clk),
        .arst_n_in  (arst_n_in),
        .load_req   (load_req),
        .a_input    (a_input),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .b_input    (b_input),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .data_ready (data_ready),
        .tile_idx   (tile_idx),
        .int_mem_re (int_mem_re),
        .ky         (ky),
        .kx         (kx),
        .outch      (outch),
        .inch       (inch),
        .y          (y),
        .x          (x),
        .a_out      (a_out),
        .b_out      (b_out),
        .rd_valid   (rd_valid)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference image and kernel, indexed the natural way.
    logic [DW-1:0] img  [H][W][CI];
    logic [DW-1:0] kern [CO][CI][K][K];

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } rd_exp_t;

    rd_exp_t       sb_q [$];
    rd_exp_t       mon_e;
    logic [DW-1:0] tx_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] a_ref(input int ry, input int rx, input int rky,
                                            input int rkx, input int rin);
        int row, col;
        row = ry + rky - P;
        col = rx + rkx - P;
        if (row < 0 || row >= H || col < 0 || col >= W) return '0;
        return img[row][col][rin];
    endfunction

    // Scoreboard monitor: every rd_valid must match the oldest outstanding read.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_rd_valid: got rd_valid=1, expected no read pending");
            end else begin
                mon_e = sb_q.pop_front();
                check("rd_a_out", 32'(a_out), 32'(mon_e.a));
                check("rd_b_out", 32'(b_out), 32'(mon_e.b));
            end
        end
    end

    task automatic fill_b();
        for (int o = 0; o < CO; o++)
            for (int i = 0; i < CI; i++)
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        tx_q.push_back(kern[o][i][r][c]);
    endtask

    // Stream order for a band: column outermost, then row, then inch.
    task automatic fill_a(input int bs, input int first, input int n);
        for (int w = first; w < first + n; w++) begin
            tx_q.push_back(img[(w / CI) % H][bs + w / (H * CI)][w % CI]);
        end
    endtask

    // Called at a negedge; returns at a negedge with valid low.
    task automatic stream(input bit is_b, input bit toggle, input string name);
        int  cyc  = 0;
        int  sent = 0;
        int  n    = tx_q.size();
        bit  v, hs;
        while (sent < n && cyc < 400) begin
            v = !toggle || (cyc % 2 == 0);
            if (is_b) begin
                b_valid = v;
                b_input = tx_q[sent];
                hs      = v && b_ready;
            end else begin
                a_valid = v;
                a_input = tx_q[sent];
                hs      = v && a_ready;
            end
            @(posedge clk);
            if (hs) sent++;
            cyc++;
            @(negedge clk);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        check(name, 32'(sent), 32'(n));
        tx_q.delete();
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic rd(input int rky, input int rkx, input int ro, input int ri, input int ry,
                      input int rx, input bit expect_valid);
        rd_exp_t e;
        int_mem_re = 1'b1;
        ky = rky; kx = rkx; outch = ro; inch = ri; y = ry; x = rx;
        if (expect_valid) begin
            e.a = a_ref(ry, rx, rky, rkx, ri);
            e.b = kern[ro][ri][rky][rkx];
            sb_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        int_mem_re = 1'b0;
    endtask

    // Output pixels inside the tile; the window may cross into the halo or off the map.
    task automatic rand_reads(input int tile, input int n);
        for (int i = 0; i < n; i++) begin
            rd($urandom_range(0, K - 1), $urandom_range(0, K - 1), $urandom_range(0, CO - 1),
               $urandom_range(0, CI - 1), $urandom_range(0, H - 1),
               tile * TW + $urandom_range(0, TW - 1), 1'b1);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
    endtask

    task automatic randomize_image();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                for (int i = 0; i < CI; i++)
                    img[r][c][i] = DW'($urandom);
        for (int o = 0; o < CO; o++)
            for (int i = 0; i < CI; i++)
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        kern[o][i][r][c] = DW'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_n_in = 1'b0; load_req = 1'b0; int_mem_re = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; a_input = '0; b_input = '0;
        ky = 0; kx = 0; outch = 0; inch = 0; y = 0; x = 0;

        // First image: kernel words are 0..35 in stream order, band 0 words 0..39.
        randomize_image();
        for (int o = 0; o < CO; o++)
            for (int i = 0; i < CI; i++)
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        kern[o][i][r][c] = DW'(((o * CI + i) * K + r) * K + c);
        for (int r = 0; r < H; r++)
            for (int c = 0; c <= TW; c++)
                for (int i = 0; i < CI; i++)
                    img[r][c][i] = DW'((c * H + r) * CI + i);

        repeat (3) @(negedge clk);
        check("rst_a_ready", 32'(a_ready), 0);
        check("rst_b_ready", 32'(b_ready), 0);
        check("rst_data_ready", 32'(data_ready), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_a_out", 32'(a_out), 0);
        check("rst_b_out", 32'(b_out), 0);
        check("rst_tile_idx", tile_idx, 0);
        arst_n_in = 1'b1;
        @(negedge clk);

        pulse_load();
        check("t0_b_ready", 32'(b_ready), 1);
        check("t0_a_ready_in_k", 32'(a_ready), 0);
        fill_b();
        stream(1'b1, 1'b0, "t0_kernel_stream");
        check("t0_a_ready", 32'(a_ready), 1);
        check("t0_b_ready_in_a", 32'(b_ready), 0);
        check("t0_data_ready_low", 32'(data_ready), 0);
        fill_a(0, 0, 40);
        stream(1'b0, 1'b0, "t0_act_stream");
        check("t0_data_ready", 32'(data_ready), 1);
        check("t0_tile_idx", tile_idx, 0);
        check("t0_a_ready_done", 32'(a_ready), 0);

        rd(1, 1, 1, 1, 2, 3, 1'b1);
        rd(0, 1, 0, 0, 0, 0, 1'b1);
        rand_reads(0, 30);

        pulse_load();
        check("t1_data_ready_fall", 32'(data_ready), 0);
        check("t1_tile_idx", tile_idx, 1);
        check("t1_a_ready", 32'(a_ready), 1);
        check("t1_b_ready", 32'(b_ready), 0);
        fill_a(TW - P, 0, 40);
        stream(1'b0, 1'b1, "t1_act_stream_gappy");
        check("t1_data_ready", 32'(data_ready), 1);
        rd(1, 2, 0, 0, 1, 7, 1'b1);
        rand_reads(1, 30);

        // Wrap to tile 0 of a new image, then reset part way through the band.
        pulse_load();
        check("wrap_tile_idx", tile_idx, 0);
        check("wrap_b_ready", 32'(b_ready), 1);
        randomize_image();
        fill_b();
        stream(1'b1, 1'b0, "img2_kernel_stream");
        fill_a(0, 0, 20);
        stream(1'b0, 1'b0, "img2_partial_stream");
        arst_n_in = 1'b0;
        #1;
        check("midrst_tile_idx", tile_idx, 0);
        check("midrst_a_ready", 32'(a_ready), 0);
        check("midrst_data_ready", 32'(data_ready), 0);
        @(negedge clk);
        arst_n_in = 1'b1;
        @(negedge clk);

        pulse_load();
        check("reload_b_ready", 32'(b_ready), 1);
        check("reload_a_ready", 32'(a_ready), 0);
        fill_b();
        stream(1'b1, 1'b1, "img2_kernel_restream");
        fill_a(0, 0, 25);
        stream(1'b0, 1'b0, "img2_act_part1");
        pulse_load();
        check("ignored_load_a_ready", 32'(a_ready), 1);
        check("ignored_load_data_ready", 32'(data_ready), 0);
        rd(1, 1, 0, 0, 1, 1, 1'b0);
        check("loada_read_rd_valid", 32'(rd_valid), 0);
        check("loada_read_a_out", 32'(a_out), 0);
        fill_a(0, 25, 14);
        stream(1'b0, 1'b0, "img2_act_part2");
        check("img2_not_ready_at_39", 32'(data_ready), 0);
        fill_a(0, 39, 1);
        stream(1'b0, 1'b0, "img2_act_last");
        check("img2_data_ready", 32'(data_ready), 1);
        rand_reads(0, 30);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
